uart_xbar: RTL and testbench

//   Parametrised successor to the round-robin UART matrix. It takes M received frames, each
//   W bits wide with a strobe, from upstream uart_rx cores. Each frame is held in a one-deep

---
 rtl/uart_xbar_pkg.sv | 22 ++
 rtl/uart_xbar_if.sv | 24 ++
 rtl/uart_xbar_slot.sv | 74 +++++++
 rtl/uart_xbar.sv | 167 ++++++++++++++++
 tb/tb_uart_xbar.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_xbar_pkg.sv
// -----------------------------------------------------------------------------
// uart_xbar_pkg
//   Shared constants and small helper functions for the uart_xbar crossbar.
//   CNT_W     : width of the optional per-input drop counters.
//   idx_w()   : width of a binary index into M slots (at least 1 bit).
//   wrap_add(): (base + off) mod m, for base < m and off <= m.
// -----------------------------------------------------------------------------
package uart_xbar_pkg;

   localparam int CNT_W = 16;

   function automatic int idx_w(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int wrap_add(input int base, input int off, input int m);
      int s;
      s = base + off;
      return (s >= m) ? s - m : s;
   endfunction

endpackage

// File: rtl/uart_xbar_if.sv
// -----------------------------------------------------------------------------
// uart_xbar_if
//   Frame path between the RX cores, the crossbar and the shared-bus TX FIFOs.
//   rx_data  M*W  received frames, input i at [i*W +: W]
//   rx_stb   M    one-cycle strobe per input
//   tx_full  N    per-FIFO full flag
//   tx       W    shared frame bus to all TX FIFOs
//   tx_cke   N    per-FIFO write enable
//   Modports: master = crossbar side, slave = RX cores / TX FIFOs side.
// -----------------------------------------------------------------------------
interface uart_xbar_if #(
   parameter int M = 8,
   parameter int N = 8,
   parameter int W = 8
);
   logic [M*W-1:0] rx_data;
   logic [M-1:0]   rx_stb;
   logic [N-1:0]   tx_full;
   logic [W-1:0]   tx;
   logic [N-1:0]   tx_cke;

   modport master (input rx_data, rx_stb, tx_full, output tx, tx_cke);
   modport slave  (output rx_data, rx_stb, tx_full, input tx, tx_cke);
endinterface

// File: rtl/uart_xbar_slot.sv
// -----------------------------------------------------------------------------
// uart_xbar_slot
//   One-deep frame holding slot for a single crossbar input.
//   clk, reset   clock, synchronous active-high reset
//   rx_stb       new frame strobe;  rx_data  the frame
//   grant        slot is consumed by the arbiter this cycle
//   overrun_clr  clears the sticky overrun flag
//   valid/frame  slot contents;  overrun  sticky frame-lost flag
//   Optional (UART_XBAR_STATS_EN): drop_tgt = per-target drops reported by the
//   top for this cycle; drop_cnt = 16-bit saturating drop counter.
// -----------------------------------------------------------------------------
module uart_xbar_slot
   import uart_xbar_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_stb,
   input  logic [W-1:0]     rx_data,
   input  logic             grant,
   input  logic             overrun_clr,
`ifdef UART_XBAR_STATS_EN
   input  logic [CNT_W-1:0] drop_tgt,
   output logic [CNT_W-1:0] drop_cnt,
`endif
   output logic             valid,
   output logic [W-1:0]     frame,
   output logic             overrun
);

   logic load;
   logic lost;

   // A grant frees the slot in the same cycle, so a strobe then still loads.
   assign load = rx_stb && (!valid || grant);
   assign lost = rx_stb && valid && !grant;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= 1'b0;
         frame   <= '0;
         overrun <= 1'b0;
      end else begin
         if (load) begin
            valid <= 1'b1;
            frame <= rx_data;
         end else if (grant) begin
            valid <= 1'b0;
         end
         // A new loss outranks a simultaneous clear.
         if (lost)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

`ifdef UART_XBAR_STATS_EN
   logic [CNT_W:0] cnt_sum;

   assign cnt_sum = {1'b0, drop_cnt} + {1'b0, drop_tgt} + (CNT_W+1)'(lost);

   always_ff @(posedge clk) begin
      if (reset || overrun_clr)
         drop_cnt <= '0;
      else
         drop_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
   end
`endif

endmodule

// File: rtl/uart_xbar.sv
// -----------------------------------------------------------------------------
// uart_xbar
//   M-input, N-output UART frame crossbar with per-input routing LUT,
//   rotating-priority work-conserving arbiter and registered shared output bus.
//   clk, reset    clock, synchronous active-high reset
//   bus           uart_xbar_if.master: rx_data/rx_stb in, tx_full in,
//                 tx/tx_cke out (registered one cycle after the grant)
//   lut_addr/lut_data/lut_we  routing LUT write port (bit j -> tx port j)
//   overrun       sticky per-input frame-lost flags; overrun_clr clears them
//   BLOCKING=1 holds a frame until all routed FIFOs are non-full;
//   BLOCKING=0 sends to non-full targets and drops the rest.
//   Optional build macro UART_XBAR_STATS_EN adds per-input saturating drop
//   counters read through cnt_sel -> cnt_out (registered, 1-cycle latency).
// -----------------------------------------------------------------------------
module uart_xbar
   import uart_xbar_pkg::*;
#(
   parameter  int M        = 8,
   parameter  int N        = 8,
   parameter  int W        = 8,
   parameter  int BLOCKING = 1,
   localparam int AW       = idx_w(M)
) (
   input  logic             clk,
   input  logic             reset,
   uart_xbar_if.master      bus,
   input  logic [AW-1:0]    lut_addr,
   input  logic [N-1:0]     lut_data,
   input  logic             lut_we,
   output logic [M-1:0]     overrun,
   input  logic             overrun_clr
`ifdef UART_XBAR_STATS_EN
   ,
   input  logic [AW-1:0]    cnt_sel,
   output logic [CNT_W-1:0] cnt_out
`endif
);

   logic [N-1:0]  lut [M];
   logic [W-1:0]  slot_frame [M];
   logic [M-1:0]  valid;
   logic [M-1:0]  elig;
   logic [M-1:0]  grant;
   logic [AW-1:0] ptr;
   logic [AW-1:0] gnt_idx;
   logic [AW-1:0] cand;
   logic          gnt_found;

`ifdef UART_XBAR_STATS_EN
   logic [CNT_W-1:0] drop_tgt [M];
   logic [CNT_W-1:0] drop_cnt [M];
`endif

   // ---------------- input slots ----------------
   for (genvar i = 0; i < M; i++) begin : g_slot
      uart_xbar_slot #(.W(W)) u_slot (
         .clk         (clk),
         .reset       (reset),
         .rx_stb      (bus.rx_stb[i]),
         .rx_data     (bus.rx_data[i*W +: W]),
         .grant       (grant[i]),
         .overrun_clr (overrun_clr),
`ifdef UART_XBAR_STATS_EN
         .drop_tgt    (drop_tgt[i]),
         .drop_cnt    (drop_cnt[i]),
`endif
         .valid       (valid[i]),
         .frame       (slot_frame[i]),
         .overrun     (overrun[i])
      );
   end

   // ---------------- routing LUT ----------------
   // NOTE: the LUT array is reset explicitly because "nothing routed" after
   // reset is functional behaviour, not just initialisation.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < M; i++)
            lut[i] <= '0;
      end else if (lut_we) begin
         // Decoding by compare means addresses >= M never match a row.
         for (int i = 0; i < M; i++)
            if (lut_addr == AW'(i))
               lut[i] <= lut_data;
      end
   end

   // ---------------- eligibility and arbitration ----------------
   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      elig = '0;
      for (int i = 0; i < M; i++)
         elig[i] = valid[i] && (BLOCKING == 0 || (lut[i] & bus.tx_full) == '0);
   end

   // First eligible slot at or after ptr, wrapping; blocked slots are skipped.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr;
      cand      = ptr;
      for (int k = 0; k < M; k++) begin
         cand = AW'(wrap_add(int'(ptr), k, M));
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (gnt_found)
         grant[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (gnt_found)
         ptr <= AW'(wrap_add(int'(gnt_idx), 1, M));
   end

   // ---------------- output register ----------------
   // The LUT row is read before the edge, so a same-cycle write to the
   // granted row only affects later frames.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.tx     <= '0;
         bus.tx_cke <= '0;
      end else if (gnt_found) begin
         bus.tx     <= slot_frame[gnt_idx];
         bus.tx_cke <= (BLOCKING != 0) ? lut[gnt_idx] : (lut[gnt_idx] & ~bus.tx_full);
      end else begin
         bus.tx_cke <= '0;
      end
   end

`ifdef UART_XBAR_STATS_EN
   // ---------------- drop statistics ----------------
   logic [CNT_W-1:0] cnt_mux;

   // Targets skipped because they were full count as drops in non-blocking mode.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         drop_tgt[i] = '0;
         if (grant[i] && BLOCKING == 0)
            drop_tgt[i] = CNT_W'($countones(lut[i] & bus.tx_full));
      end
   end

   always_comb begin
      cnt_mux = '0;
      for (int i = 0; i < M; i++)
         if (cnt_sel == AW'(i))
            cnt_mux = drop_cnt[i];
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_out <= '0;
      else
         cnt_out <= cnt_mux;
   end
`endif

endmodule

// File: tb/tb_uart_xbar.sv
// -----------------------------------------------------------------------------
// tb_uart_xbar
//   Directed bench for uart_xbar with M=4, N=4, W=8. Two instances share all
//   inputs: dut_b (BLOCKING=1) and dut_nb (BLOCKING=0). Inputs change and
//   outputs are sampled on the falling clock edge.
//   Optional build macro UART_XBAR_STATS_EN also connects the counter ports.
// -----------------------------------------------------------------------------
module tb_uart_xbar;

   localparam int M = 4;
   localparam int N = 4;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] lut_addr;
   logic [3:0] lut_data;
   logic       lut_we;
   logic       overrun_clr;
   logic [3:0] ovr_b;
   logic [3:0] ovr_nb;
`ifdef UART_XBAR_STATS_EN
   logic [1:0]  cnt_sel;
   logic [15:0] cnt_b;
   logic [15:0] cnt_nb;
`endif

   int n_cmp = 0;
   int n_err = 0;

   uart_xbar_if #(.M(M), .N(N), .W(W)) bus_b ();
   uart_xbar_if #(.M(M), .N(N), .W(W)) bus_nb ();

   assign bus_nb.rx_data = bus_b.rx_data;
   assign bus_nb.rx_stb  = bus_b.rx_stb;
   assign bus_nb.tx_full = bus_b.tx_full;

   always #5 clk = ~clk;

   uart_xbar #(.M(M), .N(N), .W(W), .BLOCKING(1)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_b),
      .lut_addr    (lut_addr),
      .lut_data    (lut_data),
      .lut_we      (lut_we),
      .overrun     (ovr_b),
      .overrun_clr (overrun_clr)
`ifdef UART_XBAR_STATS_EN
      ,
      .cnt_sel     (cnt_sel),
      .cnt_out     (cnt_b)
`endif
   );

   uart_xbar #(.M(M), .N(N), .W(W), .BLOCKING(0)) dut_nb (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_nb),
      .lut_addr    (lut_addr),
      .lut_data    (lut_data),
      .lut_we      (lut_we),
      .overrun     (ovr_nb),
      .overrun_clr (overrun_clr)
`ifdef UART_XBAR_STATS_EN
      ,
      .cnt_sel     (cnt_sel),
      .cnt_out     (cnt_nb)
`endif
   );

   typedef struct {
      logic [3:0]  stb;
      logic [31:0] data;
      logic [3:0]  full;
      logic        we;
      logic [1:0]  addr;
      logic [3:0]  ldata;
      logic        clr;
      logic [3:0]  e_cke;
      logic [7:0]  e_tx;
      logic [3:0]  e_ovr;
   } vec_t;

   vec_t vecs [30];

   function automatic vec_t v(input logic [3:0] stb, input logic [31:0] data,
                              input logic [3:0] full, input logic we,
                              input logic [1:0] addr, input logic [3:0] ldata,
                              input logic clr, input logic [3:0] e_cke,
                              input logic [7:0] e_tx, input logic [3:0] e_ovr);
      vec_t r;
      r.stb = stb;  r.data = data;  r.full = full;  r.we = we;  r.addr = addr;
      r.ldata = ldata;  r.clr = clr;  r.e_cke = e_cke;  r.e_tx = e_tx;  r.e_ovr = e_ovr;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] stb, input logic [31:0] data, input logic [3:0] full,
                        input logic we, input logic [1:0] addr, input logic [3:0] ldata,
                        input logic clr);
      bus_b.rx_stb  = stb;
      bus_b.rx_data = data;
      bus_b.tx_full = full;
      lut_we        = we;
      lut_addr      = addr;
      lut_data      = ldata;
      overrun_clr   = clr;
   endtask

   task automatic idle();
      drive(4'h0, 32'h0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Sequence 1: all rows 0001, four simultaneous strobes -> order 0..3.
      vecs[0]  = v(4'h0, 32'h0,        4'h0, 1'b1, 2'd0, 4'h1, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[1]  = v(4'h0, 32'h0,        4'h0, 1'b1, 2'd1, 4'h1, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[2]  = v(4'h0, 32'h0,        4'h0, 1'b1, 2'd2, 4'h1, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[3]  = v(4'h0, 32'h0,        4'h0, 1'b1, 2'd3, 4'h1, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[4]  = v(4'hF, 32'h44332211, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'h00, 4'h0);
      vecs[5]  = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'h11, 4'h0);
      vecs[6]  = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'h22, 4'h0);
      vecs[7]  = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'h33, 4'h0);
      vecs[8]  = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'h44, 4'h0);
      vecs[9]  = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'h44, 4'h0);
      // lut[1]=0101, A5 on input 1 -> one tx_cke pulse two cycles later.
      vecs[10] = v(4'h0, 32'h0,        4'h0, 1'b1, 2'd1, 4'h5, 1'b0, 4'h0, 8'h44, 4'h0);
      vecs[11] = v(4'h2, 32'h0000A500, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'h44, 4'h0);
      vecs[12] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h5, 8'hA5, 4'h0);
      vecs[13] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hA5, 4'h0);
      // Input 2 blocked by full FIFO 2; second strobe overruns; release; clear.
      vecs[14] = v(4'h0, 32'h0,        4'h4, 1'b1, 2'd2, 4'h4, 1'b0, 4'h0, 8'hA5, 4'h0);
      vecs[15] = v(4'h4, 32'h005A0000, 4'h4, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hA5, 4'h0);
      vecs[16] = v(4'h0, 32'h0,        4'h4, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hA5, 4'h0);
      vecs[17] = v(4'h4, 32'h00770000, 4'h4, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hA5, 4'h4);
      vecs[18] = v(4'h0, 32'h0,        4'h4, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hA5, 4'h4);
      vecs[19] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h4, 8'h5A, 4'h4);
      vecs[20] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 8'h5A, 4'h0);
      vecs[21] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'h5A, 4'h0);
      // Strobe in the cycle slot 3 is granted: reload, no overrun.
      vecs[22] = v(4'h8, 32'hC1000000, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'h5A, 4'h0);
      vecs[23] = v(4'h8, 32'hC2000000, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'hC1, 4'h0);
      vecs[24] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h1, 8'hC2, 4'h0);
      vecs[25] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hC2, 4'h0);
      // Overrun set and clear in the same cycle: set wins.
      vecs[26] = v(4'h4, 32'h005B0000, 4'h4, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 8'hC2, 4'h0);
      vecs[27] = v(4'h4, 32'h006C0000, 4'h4, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 8'hC2, 4'h4);
      vecs[28] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h4, 8'h5B, 4'h4);
      vecs[29] = v(4'h0, 32'h0,        4'h0, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0, 8'h5B, 4'h0);

      idle();
`ifdef UART_XBAR_STATS_EN
      cnt_sel = 2'd0;
`endif
      reset = 1'b1;
      tick();
      tick();
      check("reset tx",      32'(bus_b.tx),     32'h0);
      check("reset tx_cke",  32'(bus_b.tx_cke), 32'h0);
      check("reset overrun", 32'(ovr_b),        32'h0);
      reset = 1'b0;

      for (int i = 0; i < 30; i++) begin
         drive(vecs[i].stb, vecs[i].data, vecs[i].full, vecs[i].we,
               vecs[i].addr, vecs[i].ldata, vecs[i].clr);
         tick();
         check($sformatf("vec%0d tx_cke", i),  32'(bus_b.tx_cke), 32'(vecs[i].e_cke));
         check($sformatf("vec%0d tx", i),      32'(bus_b.tx),     32'(vecs[i].e_tx));
         check($sformatf("vec%0d overrun", i), 32'(ovr_b),        32'(vecs[i].e_ovr));
      end

      // ---- blocked slot skipped (BLOCKING=1) vs partial send (BLOCKING=0) ----
      idle();
      reset = 1'b1;
      tick();
      check("t4 reset b tx_cke",  32'(bus_b.tx_cke),  32'h0);
      check("t4 reset nb tx_cke", 32'(bus_nb.tx_cke), 32'h0);
      check("t4 reset nb tx",     32'(bus_nb.tx),     32'h0);
      reset = 1'b0;
      drive(4'h0, 32'h0, 4'h0, 1'b1, 2'd0, 4'h3, 1'b0);
      tick();
      drive(4'h0, 32'h0, 4'h0, 1'b1, 2'd1, 4'h4, 1'b0);
      tick();
      drive(4'h3, 32'h0000B1A0, 4'h2, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      drive(4'h0, 32'h0, 4'h2, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      check("t4 b first cke",  32'(bus_b.tx_cke),  32'h4);
      check("t4 b first tx",   32'(bus_b.tx),      32'hB1);
      check("t4 nb first cke", 32'(bus_nb.tx_cke), 32'h1);
      check("t4 nb first tx",  32'(bus_nb.tx),     32'hA0);
      tick();
      check("t4 b held cke",    32'(bus_b.tx_cke),  32'h0);
      check("t4 nb second cke", 32'(bus_nb.tx_cke), 32'h4);
      check("t4 nb second tx",  32'(bus_nb.tx),     32'hB1);
      idle();
      tick();
      check("t4 b release cke", 32'(bus_b.tx_cke),  32'h3);
      check("t4 b release tx",  32'(bus_b.tx),      32'hA0);
      check("t4 nb idle cke",   32'(bus_nb.tx_cke), 32'h0);

      // ---- LUT write to row 3 in the cycle row 3 is granted ----
      drive(4'h0, 32'h0, 4'h0, 1'b1, 2'd3, 4'h1, 1'b0);
      tick();
      drive(4'h8, 32'hD3000000, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      check("t5 load cke", 32'(bus_b.tx_cke), 32'h0);
      drive(4'h0, 32'h0, 4'h0, 1'b1, 2'd3, 4'h8, 1'b0);
      tick();
      check("t5 old row b cke",  32'(bus_b.tx_cke),  32'h1);
      check("t5 old row b tx",   32'(bus_b.tx),      32'hD3);
      check("t5 old row nb cke", 32'(bus_nb.tx_cke), 32'h1);
      drive(4'h8, 32'hE3000000, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      idle();
      tick();
      check("t5 new row cke", 32'(bus_b.tx_cke), 32'h8);
      check("t5 new row tx",  32'(bus_b.tx),     32'hE3);

      // ---- reset with three slots valid ----
      drive(4'hB, 32'h33002211, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      reset = 1'b1;
      drive(4'h1, 32'h00000055, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      check("t6 reset cke",     32'(bus_b.tx_cke), 32'h0);
      check("t6 reset overrun", 32'(ovr_b),        32'h0);
      check("t6 reset tx",      32'(bus_b.tx),     32'h0);
      idle();
      tick();
      reset = 1'b0;
      tick();
      check("t6 after release cke", 32'(bus_b.tx_cke), 32'h0);
      tick();
      check("t6 no stale cke",     32'(bus_b.tx_cke), 32'h0);
      check("t6 no stale overrun", 32'(ovr_b),        32'h0);
`ifdef UART_XBAR_STATS_EN
      check("t6 cnt0 b",  32'(cnt_b),  32'h0);
      check("t6 cnt0 nb", 32'(cnt_nb), 32'h0);
      cnt_sel = 2'd2;
      tick();
      check("t6 cnt2 b",  32'(cnt_b),  32'h0);
      check("t6 cnt2 nb", 32'(cnt_nb), 32'h0);
`endif
      // Row 0 was cleared by reset: the frame is consumed silently.
      drive(4'h1, 32'h00000099, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
      tick();
      idle();
      tick();
      check("t6 lut cleared cke", 32'(bus_b.tx_cke), 32'h0);
      check("t6 discard tx",      32'(bus_b.tx),     32'h99);
      tick();
      check("t6 final cke", 32'(bus_b.tx_cke), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
